// File: rtl/scan_mux.sv
// scan_mux: N:1 key-input selector with a registered output, plus an
// auto-scan mode. The scan walks every channel, waits DWELL settle cycles on
// each one, samples it into a working bitmap, and publishes that bitmap as
// snapshot together with any/first_idx and a one-cycle done pulse.
// Optional feature: define SCAN_DIFF_EN to register per-bit differences
// between consecutive snapshots on `changed`. Without it, `changed` is tied to 0.
module scan_mux #(
  parameter int N     = 16,
  parameter int SELW  = $clog2(N),
  parameter int DWELL = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [N-1:0]    i,
  input  logic            mode,
  input  logic [SELW-1:0] sel_in,
  input  logic            start,
  input  logic            abort,
  output logic            out,
  output logic [SELW-1:0] sel_out,
  output logic            busy,
  output logic            done,
  output logic [N-1:0]    snapshot,
  output logic            any,
  output logic [SELW-1:0] first_idx,
  output logic [N-1:0]    changed
);

  // state  | meaning
  // IDLE   | manual mux (mode=0) or waiting for start (mode=1)
  // SETTLE | driving channel ch, letting it settle for DWELL cycles
  // SAMPLE | capturing i[ch] into the working bitmap, then next channel
  // REPORT | publishing the bitmap; done pulses on the following cycle
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, REPORT} state_t;

  localparam int              DWW        = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DWW-1:0]  DW_LAST    = DWW'((DWELL > 0) ? DWELL - 1 : 0);
  localparam logic [SELW-1:0] LAST_CH    = SELW'(N - 1);
  localparam logic [SELW:0]   NUM_CH     = (SELW + 1)'(N);
  // With no settle time a channel is sampled on its first cycle.
  localparam state_t          FIRST_STEP = (DWELL == 0) ? SAMPLE : SETTLE;

  state_t          state_q;
  logic [SELW-1:0] ch_q;
  logic [DWW-1:0]  dwell_q;
  logic [N-1:0]    work_q;
  logic            out_q;
  logic [SELW-1:0] sel_out_q;
  logic            busy_q;
  logic            done_q;
  logic [N-1:0]    snapshot_q;
  logic            any_q;
  logic [SELW-1:0] first_idx_q;

  logic            man_bit_d;
  logic            ch_bit_d;
  logic            any_d;
  logic [SELW-1:0] first_idx_d;

  // Manual-path mux: selects beyond the last channel read as a constant 0.
  always_comb begin
    man_bit_d = 1'b0;
    if ({1'b0, sel_in} < NUM_CH) man_bit_d = i[sel_in];
  end

  assign ch_bit_d = i[ch_q];
  assign any_d    = |work_q;

  // Priority encoder over the working bitmap; the lowest set index wins.
  always_comb begin
    first_idx_d = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (work_q[k]) first_idx_d = SELW'(k);
    end
  end

  // Scan controller and all registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      ch_q        <= '0;
      dwell_q     <= '0;
      work_q      <= '0;
      out_q       <= 1'b0;
      sel_out_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      snapshot_q  <= '0;
      any_q       <= 1'b0;
      first_idx_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (mode && start) begin
            state_q <= FIRST_STEP;
            ch_q    <= '0;
            dwell_q <= '0;
            work_q  <= '0;
            busy_q  <= 1'b1;
          end else if (!mode) begin
            out_q     <= man_bit_d;
            sel_out_q <= sel_in;
          end
        end
        SETTLE: begin
          out_q     <= ch_bit_d;
          sel_out_q <= ch_q;
          dwell_q   <= dwell_q + DWW'(1);
          if (abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (dwell_q == DW_LAST) begin
            state_q <= SAMPLE;
          end
        end
        SAMPLE: begin
          work_q[ch_q] <= ch_bit_d;
          out_q        <= ch_bit_d;
          sel_out_q    <= ch_q;
          if (abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (ch_q == LAST_CH) begin
            state_q <= REPORT;
          end else begin
            ch_q    <= ch_q + SELW'(1);
            dwell_q <= '0;
            state_q <= FIRST_STEP;
          end
        end
        REPORT: begin
          snapshot_q  <= work_q;
          any_q       <= any_d;
          first_idx_q <= first_idx_d;
          done_q      <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef SCAN_DIFF_EN
  logic [N-1:0] changed_q;

  // Capture which bits differ from the snapshot that is about to be replaced.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) changed_q <= '0;
    else if (state_q == REPORT) changed_q <= work_q ^ snapshot_q;
  end

  assign changed = changed_q;
`else
  assign changed = '0;
`endif

  assign out       = out_q;
  assign sel_out   = sel_out_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign snapshot  = snapshot_q;
  assign any       = any_q;
  assign first_idx = first_idx_q;

endmodule

// File: tb/tb_scan_mux.sv
// Testbench for scan_mux (N=16, DWELL=2). Expected scan reports and manual
// mux results are pushed to queues when stimulus is applied and popped when
// the DUT produces them.
module tb_scan_mux;
  localparam int N        = 16;
  localparam int SELW     = 4;
  localparam int DWELL    = 2;
  localparam int SCAN_CYC = N * (DWELL + 1) + 2;
  localparam int LIMIT    = SCAN_CYC + 20;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [N-1:0]    i = '0;
  logic            mode = 1'b0;
  logic [SELW-1:0] sel_in = '0;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic            out;
  logic [SELW-1:0] sel_out;
  logic            busy;
  logic            done;
  logic [N-1:0]    snapshot;
  logic            any;
  logic [SELW-1:0] first_idx;
  logic [N-1:0]    changed;

  typedef struct packed {
    logic [N-1:0]    snap;
    logic            any;
    logic [SELW-1:0] idx;
    logic [N-1:0]    chg;
  } rep_t;

  typedef struct packed {
    logic            o;
    logic [SELW-1:0] s;
  } man_t;

  rep_t         exp_q[$];
  man_t         man_q[$];
  logic [N-1:0] model_snap = '0;
  int           n_checks = 0;
  int           n_fail = 0;

  scan_mux #(.N(N), .SELW(SELW), .DWELL(DWELL)) dut (
    .clk(clk), .reset_n(reset_n), .i(i), .mode(mode), .sel_in(sel_in),
    .start(start), .abort(abort), .out(out), .sel_out(sel_out), .busy(busy),
    .done(done), .snapshot(snapshot), .any(any), .first_idx(first_idx),
    .changed(changed)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic rep_t model_scan(input logic [N-1:0] pat);
    rep_t r;
    r.snap = pat;
    r.any  = |pat;
    r.idx  = '0;
    for (int k = N - 1; k >= 0; k--) if (pat[k]) r.idx = SELW'(k);
`ifdef SCAN_DIFF_EN
    r.chg = pat ^ model_snap;
`else
    r.chg = '0;
`endif
    return r;
  endfunction

  task automatic test_reset;
    int   cyc;
    logic seen_done;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({out, sel_out, busy, done, snapshot, any, first_idx, changed} !== '0) begin
      n_fail++;
      $display("FAIL reset_init: outputs=%h required 0",
               {out, sel_out, busy, done, snapshot, any, first_idx, changed});
    end
    tick;
    reset_n = 1'b1;
    tick;
    i = 16'hFFFF; mode = 1'b1; start = 1'b1;
    tick;
    start = 1'b0;
    cyc = 1;
    while (cyc < 23) begin tick; cyc++; end
    n_checks++;
    if (sel_out !== 4'd7 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_midscan_pos: sel_out=%0d busy=%b required 7 1", sel_out, busy);
    end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({out, sel_out, busy, done, snapshot, any, first_idx, changed} !== '0) begin
      n_fail++;
      $display("FAIL reset_midscan: outputs=%h required 0",
               {out, sel_out, busy, done, snapshot, any, first_idx, changed});
    end
    tick; tick;
    reset_n = 1'b1;
    model_snap = '0;
    seen_done = 1'b0;
    for (int k = 0; k < 60; k++) begin
      tick;
      if (done === 1'b1 || busy === 1'b1) seen_done = 1'b1;
    end
    n_checks++;
    if (seen_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_done: saw done/busy after reset=%b required 0", seen_done);
    end
  endtask

  task automatic test_manual;
    logic [N-1:0]    pats [7] = '{16'h8001, 16'h8001, 16'h8001, 16'h8001, 16'h4002, 16'h4002, 16'h4002};
    logic [SELW-1:0] sels [7] = '{4'd0, 4'd15, 4'd5, 4'd1, 4'd1, 4'd14, 4'd15};
    logic [SELW-1:0] prev;
    man_t            m;
    man_t            e;
    mode = 1'b0;
    start = 1'b1;
    prev = '0;
    for (int k = 0; k < 7; k++) begin
      i = pats[k];
      sel_in = sels[k];
      m.o = pats[k][sels[k]];
      m.s = sels[k];
      man_q.push_back(m);
      if (k > 0) begin
        n_checks++;
        if (sel_out !== prev) begin
          n_fail++;
          $display("FAIL manual_lag[%0d]: sel_out=%0d required %0d", k, sel_out, prev);
        end
      end
      tick;
      e = man_q.pop_front();
      n_checks++;
      if (out !== e.o || sel_out !== e.s) begin
        n_fail++;
        $display("FAIL manual[%0d]: out=%b sel_out=%0d required %b %0d", k, out, sel_out, e.o, e.s);
      end
      prev = sels[k];
    end
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL manual_start_ignored: busy=%b required 0", busy);
    end
  endtask

  task automatic test_full_scan;
    int   cyc;
    logic gap;
    rep_t e;
    i = 16'h0420; mode = 1'b1;
    exp_q.push_back(model_scan(i));
    model_snap = i;
    start = 1'b1;
    tick;
    start = 1'b0;
    cyc = 1;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL full_busy_rise: busy=%b required 1", busy);
    end
    gap = 1'b0;
    while (done !== 1'b1 && cyc < LIMIT) begin
      if (busy !== 1'b1) gap = 1'b1;
      tick; cyc++;
    end
    n_checks++;
    if (cyc != SCAN_CYC || gap) begin
      n_fail++;
      $display("FAIL full_done_cycle: done at cycle %0d busy_gap=%b required %0d 0", cyc, gap, SCAN_CYC);
    end
    e = exp_q.pop_front();
    n_checks++;
    if (snapshot !== e.snap || any !== e.any || first_idx !== e.idx || changed !== e.chg) begin
      n_fail++;
      $display("FAIL full_report: snap=%h any=%b idx=%0d chg=%h required %h %b %0d %h",
               snapshot, any, first_idx, changed, e.snap, e.any, e.idx, e.chg);
    end
    tick;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL full_done_pulse: done=%b busy=%b required 0 0", done, busy);
    end
  endtask

  task automatic test_abort;
    int   cyc;
    logic seen;
    rep_t e;
    e = model_scan(model_snap);
    i = 16'hFFFF; mode = 1'b1; start = 1'b1;
    tick;
    start = 1'b0;
    cyc = 1;
    while (cyc < 20) begin tick; cyc++; end
    abort = 1'b1;
    tick;
    abort = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_busy: busy=%b done=%b required 0 0", busy, done);
    end
    n_checks++;
    if (snapshot !== e.snap || any !== e.any || first_idx !== e.idx) begin
      n_fail++;
      $display("FAIL abort_hold: snap=%h any=%b idx=%0d required %h %b %0d",
               snapshot, any, first_idx, e.snap, e.any, e.idx);
    end
    i = '0;
    seen = 1'b0;
    for (int k = 0; k < 60; k++) begin
      tick;
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_no_done: saw done/busy=%b required 0", seen);
    end
  endtask

  task automatic test_start_while_busy;
    int   cyc;
    rep_t e;
    i = 16'h0021; mode = 1'b1; sel_in = 4'd0;
    exp_q.push_back(model_scan(i));
    model_snap = i;
    start = 1'b1;
    tick;
    cyc = 1;
    while (done !== 1'b1 && cyc < LIMIT) begin
      start = (cyc == 10);
      if (cyc == 15) begin mode = 1'b0; sel_in = 4'd5; end
      tick; cyc++;
    end
    start = 1'b0;
    n_checks++;
    if (cyc != SCAN_CYC) begin
      n_fail++;
      $display("FAIL busy_start_cycle: done at cycle %0d required %0d", cyc, SCAN_CYC);
    end
    e = exp_q.pop_front();
    n_checks++;
    if (snapshot !== e.snap || any !== e.any || first_idx !== e.idx || changed !== e.chg) begin
      n_fail++;
      $display("FAIL busy_start_report: snap=%h any=%b idx=%0d chg=%h required %h %b %0d %h",
               snapshot, any, first_idx, changed, e.snap, e.any, e.idx, e.chg);
    end
    tick;
    n_checks++;
    if (out !== 1'b1 || sel_out !== 4'd5) begin
      n_fail++;
      $display("FAIL busy_return_manual: out=%b sel_out=%0d required 1 5", out, sel_out);
    end
    mode = 1'b1;
  endtask

  task automatic test_empty_and_glitch;
    int   cyc;
    rep_t e;
    i = '0; mode = 1'b1;
    exp_q.push_back(model_scan(i));
    model_snap = i;
    start = 1'b1;
    tick;
    start = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < LIMIT) begin tick; cyc++; end
    e = exp_q.pop_front();
    n_checks++;
    if (cyc != SCAN_CYC || snapshot !== e.snap || any !== e.any || first_idx !== e.idx || changed !== e.chg) begin
      n_fail++;
      $display("FAIL empty_report: cyc=%0d snap=%h any=%b idx=%0d chg=%h required %0d %h %b %0d %h",
               cyc, snapshot, any, first_idx, changed, SCAN_CYC, e.snap, e.any, e.idx, e.chg);
    end
    tick;
    exp_q.push_back(model_scan(16'h0008));
    model_snap = 16'h0008;
    start = 1'b1;
    tick;
    start = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < LIMIT) begin
      i = '0;
      i[3] = (cyc == 10 || cyc == 12);
      tick; cyc++;
    end
    i = '0;
    e = exp_q.pop_front();
    n_checks++;
    if (cyc != SCAN_CYC || snapshot !== e.snap || any !== e.any || first_idx !== e.idx || changed !== e.chg) begin
      n_fail++;
      $display("FAIL glitch_report: cyc=%0d snap=%h any=%b idx=%0d chg=%h required %0d %h %b %0d %h",
               cyc, snapshot, any, first_idx, changed, SCAN_CYC, e.snap, e.any, e.idx, e.chg);
    end
  endtask

  initial begin
    test_reset();
    test_manual();
    test_full_scan();
    test_abort();
    test_start_while_busy();
    test_empty_and_glitch();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
